// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the starship game timer slice.
// State encoding and BCD digit limits used by the top and the digit cells.
package nexys_starship_pkg;

    typedef enum logic [1:0] {
        TIMER_IDLE   = 2'd0,
        TIMER_RUN    = 2'd1,
        TIMER_FROZEN = 2'd2
    } timer_state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/nexys_starship_game_timer_if.sv
// Game-state inputs and display/difficulty outputs of the game timer.
// The game side uses master; the timer itself uses slave.
interface nexys_starship_game_timer_if;
    logic       play_flag;
    logic       gameover_ctrl;
    logic       pause;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [2:0] level;
    logic       sec_pulse;
    logic       time_max;
    logic       q_Idle;
    logic       q_Run;
    logic       q_Frozen;

    modport master (
        output play_flag, gameover_ctrl, pause,
        input  sec_ones, sec_tens, min_ones, min_tens, level,
        input  sec_pulse, time_max, q_Idle, q_Run, q_Frozen
    );

    modport slave (
        input  play_flag, gameover_ctrl, pause,
        output sec_ones, sec_tens, min_ones, min_tens, level,
        output sec_pulse, time_max, q_Idle, q_Run, q_Frozen
    );
endinterface

// File: rtl/nexys_starship_bcd_digit.sv
// One registered BCD digit that wraps at MAX; carry is the combinational
// roll-over request passed to the next, more significant digit.
module nexys_starship_bcd_digit
    import nexys_starship_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       hold,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_reg;

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            value_reg <= 4'd0;
        end else if (inc && !hold) begin
            value_reg <= (value_reg == MAX) ? 4'd0 : value_reg + 4'd1;
        end
    end

    assign value = value_reg;
    assign carry = inc && (value_reg == MAX);

endmodule

// File: rtl/nexys_starship_game_timer.sv
// Elapsed play time (MM:SS in BCD) and difficulty level for the starship game.
// Counts only while in Run; freezes on game over and clears on return to Idle.
module nexys_starship_game_timer
    import nexys_starship_pkg::*;
#(
    parameter int TICK_DIV       = 100000000,
    parameter int LEVEL_PERIOD_S = 30,
    parameter int MAX_LEVEL      = 7
) (
    input  logic                          Clk,
    input  logic                          Reset,
    nexys_starship_game_timer_if.slave    bus
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [6:0]      LSEC_LAST = 7'(LEVEL_PERIOD_S - 1);
    localparam logic [2:0]      LEVEL_TOP = 3'(MAX_LEVEL);

    timer_state_t  state_reg, state_next;
    logic [PW-1:0] pre_reg, pre_next;
    logic [6:0]    level_sec_reg;
    logic [2:0]    level_reg;
    logic          sec_pulse_reg, time_max_reg;
    logic          q_idle_reg, q_run_reg, q_frozen_reg;
    logic          count_en, tick, clr;
    logic          at_ceiling, at_last_step;
    logic [3:0]    digit [4];
    logic [4:0]    carry_chain;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= TIMER_IDLE;
            pre_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
        end
    end

    // Game over outranks a coincident tick; leaving Run for Idle clears everything.
    always_comb begin
        state_next = state_reg;
        count_en   = 1'b0;
        unique case (state_reg)
            TIMER_IDLE: begin
                if (bus.play_flag && !bus.gameover_ctrl) state_next = TIMER_RUN;
            end
            TIMER_RUN: begin
                if (bus.gameover_ctrl)   state_next = TIMER_FROZEN;
                else if (!bus.play_flag) state_next = TIMER_IDLE;
                else                     count_en   = !bus.pause;
            end
            TIMER_FROZEN: begin
                if (!bus.play_flag && !bus.gameover_ctrl) state_next = TIMER_IDLE;
            end
            default: state_next = TIMER_IDLE;
        endcase
    end

    assign tick = count_en && (pre_reg == PRE_LAST);
    assign clr  = (state_next == TIMER_IDLE);

    always_comb begin
        pre_next = pre_reg;
        if (clr)           pre_next = '0;
        else if (count_en) pre_next = (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
    end

    // Digit chain: sec_ones, sec_tens, min_ones, min_tens; frozen as a whole at 99:59.
    assign carry_chain[0] = tick;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            nexys_starship_bcd_digit #(
                .MAX ((gi == 1) ? SEC_TENS_MAX : DIGIT_MAX)
            ) u_digit (
                .Clk   (Clk),
                .Reset (Reset),
                .clr   (clr),
                .inc   (carry_chain[gi]),
                .hold  (at_ceiling),
                .value (digit[gi]),
                .carry (carry_chain[gi+1])
            );
        end
    endgenerate

    assign at_ceiling   = (digit[3] == 4'd9) && (digit[2] == 4'd9) &&
                          (digit[1] == 4'd5) && (digit[0] == 4'd9);
    assign at_last_step = (digit[3] == 4'd9) && (digit[2] == 4'd9) &&
                          (digit[1] == 4'd5) && (digit[0] == 4'd8);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            level_sec_reg <= '0;
            level_reg     <= '0;
            sec_pulse_reg <= 1'b0;
            time_max_reg  <= 1'b0;
            q_idle_reg    <= 1'b1;
            q_run_reg     <= 1'b0;
            q_frozen_reg  <= 1'b0;
        end else begin
            sec_pulse_reg <= tick;
            q_idle_reg    <= (state_next == TIMER_IDLE);
            q_run_reg     <= (state_next == TIMER_RUN);
            q_frozen_reg  <= (state_next == TIMER_FROZEN);
            // A tick arriving while already at the ceiling (carry out of min_tens) also keeps it set.
            time_max_reg  <= !clr && (time_max_reg || at_ceiling ||
                                      (tick && at_last_step) || carry_chain[4]);
            if (clr) begin
                level_sec_reg <= '0;
                level_reg     <= '0;
            end else if (tick) begin
                if (level_sec_reg == LSEC_LAST) begin
                    level_sec_reg <= '0;
                    if (level_reg < LEVEL_TOP) level_reg <= level_reg + 3'd1;
                end else begin
                    level_sec_reg <= level_sec_reg + 7'd1;
                end
            end
        end
    end

    assign bus.sec_ones  = digit[0];
    assign bus.sec_tens  = digit[1];
    assign bus.min_ones  = digit[2];
    assign bus.min_tens  = digit[3];
    assign bus.level     = level_reg;
    assign bus.sec_pulse = sec_pulse_reg;
    assign bus.time_max  = time_max_reg;
    assign bus.q_Idle    = q_idle_reg;
    assign bus.q_Run     = q_run_reg;
    assign bus.q_Frozen  = q_frozen_reg;

endmodule

// File: tb/tb_nexys_starship_game_timer.sv
// Directed bench for the game timer with TICK_DIV=4, LEVEL_PERIOD_S=3, MAX_LEVEL=7.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_nexys_starship_game_timer;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    nexys_starship_game_timer_if tif();

    nexys_starship_game_timer #(
        .TICK_DIV       (4),
        .LEVEL_PERIOD_S (3),
        .MAX_LEVEL      (7)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (tif)
    );

    always #5 Clk = ~Clk;

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic check_time(input string tag, input int mt, input int mo,
                              input int st, input int so);
        check_val({tag, "_min_tens"}, int'(tif.min_tens), mt);
        check_val({tag, "_min_ones"}, int'(tif.min_ones), mo);
        check_val({tag, "_sec_tens"}, int'(tif.sec_tens), st);
        check_val({tag, "_sec_ones"}, int'(tif.sec_ones), so);
    endtask

    initial begin
        Reset             = 1'b1;
        tif.play_flag     = 1'b0;
        tif.gameover_ctrl = 1'b0;
        tif.pause         = 1'b0;
        step(2);
        Reset = 1'b0;

        // Reset state
        check_val("rst_q_idle", int'(tif.q_Idle), 1);
        check_val("rst_q_run", int'(tif.q_Run), 0);
        check_time("rst", 0, 0, 0, 0);
        check_val("rst_level", int'(tif.level), 0);
        check_val("rst_pulse", int'(tif.sec_pulse), 0);
        check_val("rst_time_max", int'(tif.time_max), 0);

        // 1: entry into Run and first pulse after TICK_DIV cycles
        tif.play_flag = 1'b1;
        step(1);
        check_val("t1_q_run", int'(tif.q_Run), 1);
        check_val("t1_q_idle", int'(tif.q_Idle), 0);
        step(3);
        check_val("t1_no_early_pulse", int'(tif.sec_pulse), 0);
        step(1);
        check_val("t1_first_pulse", int'(tif.sec_pulse), 1);
        check_time("t1_first", 0, 0, 0, 1);
        step(1);
        check_val("t1_pulse_one_cycle", int'(tif.sec_pulse), 0);
        step(35);
        check_val("t1_pulse10", int'(tif.sec_pulse), 1);
        check_time("t1_10s", 0, 0, 1, 0);
        check_val("t1_level", int'(tif.level), 3);

        // 2: 00:59 -> 01:00, level saturated
        step(4 * 49);
        check_time("t2_59s", 0, 0, 5, 9);
        step(4);
        check_time("t2_60s", 0, 1, 0, 0);
        check_val("t2_level_sat", int'(tif.level), 7);

        // 3: pause for 20 cycles with prescaler at 2
        step(2);
        tif.pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_val("t3_pause_pulse", int'(tif.sec_pulse), 0);
        end
        check_time("t3_paused", 0, 1, 0, 0);
        tif.pause = 1'b0;
        step(1);
        check_val("t3_remainder_early", int'(tif.sec_pulse), 0);
        step(1);
        check_val("t3_remainder_pulse", int'(tif.sec_pulse), 1);
        check_time("t3_after", 0, 1, 0, 1);

        // 4: game over coincident with the tick
        step(3);
        tif.gameover_ctrl = 1'b1;
        step(1);
        check_val("t4_no_pulse", int'(tif.sec_pulse), 0);
        check_val("t4_q_frozen", int'(tif.q_Frozen), 1);
        check_time("t4_held", 0, 1, 0, 1);
        step(5);
        check_val("t4_still_frozen", int'(tif.q_Frozen), 1);
        check_time("t4_held_later", 0, 1, 0, 1);
        tif.play_flag     = 1'b0;
        tif.gameover_ctrl = 1'b0;
        step(1);
        check_val("t4_q_idle", int'(tif.q_Idle), 1);
        check_time("t4_cleared", 0, 0, 0, 0);
        check_val("t4_level", int'(tif.level), 0);

        // 5: run to the 99:59 ceiling
        tif.play_flag = 1'b1;
        step(1);
        step(4 * 5998);
        check_time("t5_5998", 9, 9, 5, 8);
        check_val("t5_time_max_before", int'(tif.time_max), 0);
        step(4);
        check_time("t5_5999", 9, 9, 5, 9);
        check_val("t5_time_max", int'(tif.time_max), 1);
        step(4);
        check_time("t5_saturated", 9, 9, 5, 9);
        check_val("t5_pulse_at_max", int'(tif.sec_pulse), 1);
        check_val("t5_time_max_held", int'(tif.time_max), 1);

        // 6: synchronous reset mid-Run at 00:37
        tif.play_flag = 1'b0;
        step(1);
        tif.play_flag = 1'b1;
        step(1);
        step(4 * 37);
        check_time("t6_37s", 0, 0, 3, 7);
        check_val("t6_level", int'(tif.level), 7);
        Reset = 1'b1;
        step(1);
        check_time("t6_reset", 0, 0, 0, 0);
        check_val("t6_level_reset", int'(tif.level), 0);
        check_val("t6_q_idle", int'(tif.q_Idle), 1);
        check_val("t6_pulse", int'(tif.sec_pulse), 0);
        check_val("t6_time_max", int'(tif.time_max), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
